// File: rtl/tile_scheduler_pkg.sv
// tile_sched_pkg: shared types and default constants for the tile scheduler.
//   tile_sched_state_t : FSM state encoding used by tile_scheduler.
//   DEF_*              : default parameter values (PE count, address width,
//                        vector / matrix / result base addresses).
// Optional feature macro used elsewhere in this slice: TILE_SCHED_PERF_EN.
package tile_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    STORE = 3'd4,
    FIN   = 3'd5
  } tile_sched_state_t;

  localparam int unsigned DEF_PE_NUMBER = 32'd20;
  localparam int unsigned DEF_ADDR_W    = 32'd10;
  localparam int unsigned DEF_VEC_BASE  = 32'd0;
  localparam int unsigned DEF_MAT_BASE  = 32'd64;
  localparam int unsigned DEF_RES_BASE  = 32'd960;

endpackage

// File: rtl/tile_scheduler_if.sv
// tile_sched_if: host <-> scheduler bus.
//   Host side (master) drives : start, mat_rows, mat_cols.
//   Scheduler (slave) drives  : busy, done, arr_reset, read, l_d_o_addr,
//                               w_base_addr, res_wen, res_waddr
//                               (+ perf_cycles when TILE_SCHED_PERF_EN is defined).
interface tile_sched_if
  import tile_sched_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
);
  logic              start;
  logic [ADDR_W-1:0] mat_rows;
  logic [ADDR_W-1:0] mat_cols;
  logic              busy;
  logic              done;
  logic              arr_reset;
  logic              read;
  logic [ADDR_W-1:0] l_d_o_addr;
  logic [ADDR_W-1:0] w_base_addr;
  logic              res_wen;
  logic [ADDR_W-1:0] res_waddr;
`ifdef TILE_SCHED_PERF_EN
  logic [31:0]       perf_cycles;
`endif

  modport master (
    output start, mat_rows, mat_cols,
`ifdef TILE_SCHED_PERF_EN
    input  perf_cycles,
`endif
    input  busy, done, arr_reset, read, l_d_o_addr, w_base_addr, res_wen, res_waddr
  );

  modport slave (
    input  start, mat_rows, mat_cols,
`ifdef TILE_SCHED_PERF_EN
    output perf_cycles,
`endif
    output busy, done, arr_reset, read, l_d_o_addr, w_base_addr, res_wen, res_waddr
  );

endinterface

// File: rtl/tile_scheduler_addr_gen.sv
// tile_addr_gen: per-tile address arithmetic for the scheduler.
//   rows, cols : latched job dimensions
//   tile       : current tile index
//   row_base   : tile*PE_NUMBER            (mod 2^ADDR_W), first result row
//   mat_base   : tile*PE_NUMBER*cols       (mod 2^ADDR_W), matrix offset of PE0
//   n_rows     : min(PE_NUMBER, rows - tile*PE_NUMBER), rows written this tile
//   last_tile  : no rows remain after this tile
module tile_addr_gen
  import tile_sched_pkg::*;
#(
  parameter int unsigned PE_NUMBER = DEF_PE_NUMBER,
  parameter int unsigned ADDR_W    = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] rows,
  input  logic [ADDR_W-1:0] cols,
  input  logic [ADDR_W-1:0] tile,
  output logic [ADDR_W-1:0] row_base,
  output logic [ADDR_W-1:0] mat_base,
  output logic [ADDR_W-1:0] n_rows,
  output logic              last_tile
);

  logic [31:0] row_base_full_s;
  logic [31:0] rows_rem_s;
  logic [31:0] mat_base_full_s;

  // Row/matrix offsets are formed at 32 bits so the remaining-row test is exact;
  // only the address outputs are truncated (silent wrap).
  always_comb begin
    row_base_full_s = 32'(tile) * 32'(PE_NUMBER);
    rows_rem_s      = 32'(rows) - row_base_full_s;
    mat_base_full_s = row_base_full_s * 32'(cols);
    row_base        = row_base_full_s[ADDR_W-1:0];
    mat_base        = mat_base_full_s[ADDR_W-1:0];
    if (rows_rem_s > 32'(PE_NUMBER)) begin
      n_rows    = ADDR_W'(PE_NUMBER);
      last_tile = 1'b0;
    end else begin
      n_rows    = rows_rem_s[ADDR_W-1:0];
      last_tile = 1'b1;
    end
  end

endmodule

// File: rtl/tile_scheduler.sv
// tile_scheduler: sequences a matrix-vector job over a PE_NUMBER-row systolic
// array, one tile of PE_NUMBER matrix rows at a time:
//   CLEAR (1 cycle) -> FEED (cols cycles) -> DRAIN (PE_NUMBER-1 cycles)
//   -> STORE (valid rows of the tile) -> next tile or FIN.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : tile_sched_if.slave (start/mat_rows/mat_cols in; busy, done,
//           arr_reset, read, l_d_o_addr, w_base_addr, res_wen, res_waddr out)
// Optional: define TILE_SCHED_PERF_EN to add bus.perf_cycles, which counts
// the job's cycles from the start cycle through the done cycle inclusive.
// All outputs are registered and computed from the next state, so they line
// up with the state they belong to.
module tile_scheduler
  import tile_sched_pkg::*;
#(
  parameter int unsigned PE_NUMBER = DEF_PE_NUMBER,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned VEC_BASE  = DEF_VEC_BASE,
  parameter int unsigned MAT_BASE  = DEF_MAT_BASE,
  parameter int unsigned RES_BASE  = DEF_RES_BASE
) (
  input logic         clk,
  input logic         rst_n,
  tile_sched_if.slave bus
);

  localparam logic [ADDR_W-1:0] VEC_BASE_A  = ADDR_W'(VEC_BASE);
  localparam logic [ADDR_W-1:0] MAT_BASE_A  = ADDR_W'(MAT_BASE);
  localparam logic [ADDR_W-1:0] RES_BASE_A  = ADDR_W'(RES_BASE);
  localparam logic [ADDR_W-1:0] DRAIN_LAST  = ADDR_W'(PE_NUMBER - 32'd2);

  tile_sched_state_t state_r;
  logic [ADDR_W-1:0] rows_r;
  logic [ADDR_W-1:0] cols_r;
  logic [ADDR_W-1:0] tile_r;
  logic [ADDR_W-1:0] cnt_r;
  logic              busy_r;
  logic              done_r;
  logic              arr_reset_r;
  logic              read_r;
  logic              res_wen_r;
  logic [ADDR_W-1:0] l_d_o_addr_r;
  logic [ADDR_W-1:0] w_base_addr_r;
  logic [ADDR_W-1:0] res_waddr_r;

  logic [ADDR_W-1:0] cnt_inc_s;
  logic [ADDR_W-1:0] row_base_s;
  logic [ADDR_W-1:0] mat_base_s;
  logic [ADDR_W-1:0] n_rows_s;
  logic              last_tile_s;

  assign cnt_inc_s = cnt_r + ADDR_W'(1);

  tile_addr_gen #(
    .PE_NUMBER (PE_NUMBER),
    .ADDR_W    (ADDR_W)
  ) u_addr_gen (
    .rows      (rows_r),
    .cols      (cols_r),
    .tile      (tile_r),
    .row_base  (row_base_s),
    .mat_base  (mat_base_s),
    .n_rows    (n_rows_s),
    .last_tile (last_tile_s)
  );

  // Job FSM: state, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      rows_r        <= '0;
      cols_r        <= '0;
      tile_r        <= '0;
      cnt_r         <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      arr_reset_r   <= 1'b0;
      read_r        <= 1'b0;
      res_wen_r     <= 1'b0;
      l_d_o_addr_r  <= '0;
      w_base_addr_r <= '0;
      res_waddr_r   <= '0;
    end else begin
      // strobes are single-cycle unless the next state re-asserts them
      arr_reset_r <= 1'b0;
      read_r      <= 1'b0;
      res_wen_r   <= 1'b0;
      done_r      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            if ((bus.mat_rows != '0) && (bus.mat_cols != '0)) begin
              rows_r      <= bus.mat_rows;
              cols_r      <= bus.mat_cols;
              tile_r      <= '0;
              cnt_r       <= '0;
              busy_r      <= 1'b1;
              arr_reset_r <= 1'b1;
              state_r     <= CLEAR;
            end else begin
              // empty job: straight to the done pulse, array untouched
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= FIN;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CLEAR: begin
          cnt_r         <= '0;
          read_r        <= 1'b1;
          l_d_o_addr_r  <= VEC_BASE_A;
          w_base_addr_r <= MAT_BASE_A + mat_base_s;
          state_r       <= FEED;
        end
        FEED: begin
          read_r <= 1'b1;
          if (cnt_r == (cols_r - ADDR_W'(1))) begin
            cnt_r <= '0;
            if (PE_NUMBER > 32'd1) begin
              state_r <= DRAIN;
            end else begin
              // single-PE array has no skew to flush
              res_wen_r   <= 1'b1;
              res_waddr_r <= RES_BASE_A + row_base_s;
              state_r     <= STORE;
            end
          end else begin
            cnt_r         <= cnt_inc_s;
            l_d_o_addr_r  <= VEC_BASE_A + cnt_inc_s;
            w_base_addr_r <= MAT_BASE_A + mat_base_s + cnt_inc_s;
            state_r       <= FEED;
          end
        end
        DRAIN: begin
          read_r <= 1'b1;
          if (cnt_r == DRAIN_LAST) begin
            cnt_r       <= '0;
            res_wen_r   <= 1'b1;
            res_waddr_r <= RES_BASE_A + row_base_s;
            state_r     <= STORE;
          end else begin
            cnt_r   <= cnt_inc_s;
            state_r <= DRAIN;
          end
        end
        STORE: begin
          if (cnt_r == (n_rows_s - ADDR_W'(1))) begin
            cnt_r <= '0;
            if (last_tile_s) begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= FIN;
            end else begin
              tile_r      <= tile_r + ADDR_W'(1);
              arr_reset_r <= 1'b1;
              state_r     <= CLEAR;
            end
          end else begin
            cnt_r       <= cnt_inc_s;
            read_r      <= 1'b1;
            res_wen_r   <= 1'b1;
            res_waddr_r <= RES_BASE_A + row_base_s + cnt_inc_s;
            state_r     <= STORE;
          end
        end
        FIN: begin
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef TILE_SCHED_PERF_EN
  logic [31:0] perf_cycles_r;

  // Job cycle counter: loads 1 for the start cycle, then counts every
  // non-idle cycle, so it holds the full job length after done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cycles_r <= 32'd0;
    end else if (state_r == IDLE) begin
      if (bus.start) begin
        perf_cycles_r <= 32'd1;
      end else begin
        perf_cycles_r <= perf_cycles_r;
      end
    end else begin
      perf_cycles_r <= perf_cycles_r + 32'd1;
    end
  end

  assign bus.perf_cycles = perf_cycles_r;
`endif

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.arr_reset   = arr_reset_r;
  assign bus.read        = read_r;
  assign bus.l_d_o_addr  = l_d_o_addr_r;
  assign bus.w_base_addr = w_base_addr_r;
  assign bus.res_wen     = res_wen_r;
  assign bus.res_waddr   = res_waddr_r;

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed bench for tile_scheduler (PE_NUMBER=20, ADDR_W=10, default bases).
// Cycle m = observation after the m-th rising edge following the start pulse
// (the edge that samples start is m=1).
module tb_tile_scheduler;
  import tile_sched_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  tile_sched_if #(.ADDR_W(10)) bus ();

  tile_scheduler #(
    .PE_NUMBER (20),
    .ADDR_W    (10),
    .VEC_BASE  (0),
    .MAT_BASE  (64),
    .RES_BASE  (960)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic       r_arr  [0:255];
  logic       r_read [0:255];
  logic       r_wen  [0:255];
  logic       r_done [0:255];
  logic       r_busy [0:255];
  logic       r_idle [0:255];
  logic [9:0] r_ldo  [0:255];
  logic [9:0] r_wb   [0:255];
  logic [9:0] r_wa   [0:255];
  int done_idx, done_cnt, read_cnt, arr_cnt, wen_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse start with (rows, cols), record window cycles. restart_at / rst_at
  // name the edge that samples an extra start (rows=cols=1) or rst_n=0.
  task automatic run_job(input logic [9:0] rows, input logic [9:0] cols,
                         input int window, input int restart_at, input int rst_at);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.mat_rows = rows;
    bus.mat_cols = cols;
    for (int m = 1; m <= window; m++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      rst_n     = 1'b1;
      @(negedge clk);
      r_arr[m]  = bus.arr_reset;
      r_read[m] = bus.read;
      r_wen[m]  = bus.res_wen;
      r_done[m] = bus.done;
      r_busy[m] = bus.busy;
      r_idle[m] = (dut.state_r == IDLE);
      r_ldo[m]  = bus.l_d_o_addr;
      r_wb[m]   = bus.w_base_addr;
      r_wa[m]   = bus.res_waddr;
      if (m + 1 == restart_at) begin
        bus.start    = 1'b1;
        bus.mat_rows = 10'd1;
        bus.mat_cols = 10'd1;
      end
      if (m + 1 == rst_at) begin
        rst_n = 1'b0;
      end
    end
    done_idx = -1; done_cnt = 0; read_cnt = 0; arr_cnt = 0; wen_cnt = 0;
    for (int m = 1; m <= window; m++) begin
      if (r_done[m] === 1'b1) begin
        done_cnt++;
        if (done_idx < 0) done_idx = m;
      end
      if (r_read[m] === 1'b1) read_cnt++;
      if (r_arr[m]  === 1'b1) arr_cnt++;
      if (r_wen[m]  === 1'b1) wen_cnt++;
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.mat_rows = 10'd0;
    bus.mat_cols = 10'd0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_read",  32'(bus.read), 32'd0);
    chk("rst_arr",   32'(bus.arr_reset), 32'd0);
    chk("rst_wen",   32'(bus.res_wen), 32'd0);
    chk("rst_wa",    32'(bus.res_waddr), 32'd0);
    rst_n = 1'b1;

    // Job 1: rows=4 cols=3 -> one tile, done at m=28
    run_job(10'd4, 10'd3, 35, 0, 0);
    chk("j1_m1_arr",    32'(r_arr[1]), 32'd1);
    chk("j1_m1_busy",   32'(r_busy[1]), 32'd1);
    chk("j1_m1_read",   32'(r_read[1]), 32'd0);
    chk("j1_arr_cnt",   32'(arr_cnt), 32'd1);
    chk("j1_ldo_m2",    32'(r_ldo[2]), 32'd0);
    chk("j1_ldo_m3",    32'(r_ldo[3]), 32'd1);
    chk("j1_ldo_m4",    32'(r_ldo[4]), 32'd2);
    chk("j1_wb_m2",     32'(r_wb[2]), 32'd64);
    chk("j1_wb_m4",     32'(r_wb[4]), 32'd66);
    chk("j1_read_m23",  32'(r_read[23]), 32'd1);
    chk("j1_wen_m23",   32'(r_wen[23]), 32'd0);
    chk("j1_read_cnt",  32'(read_cnt), 32'd26);
    chk("j1_wen_cnt",   32'(wen_cnt), 32'd4);
    chk("j1_wa_m24",    32'(r_wa[24]), 32'd960);
    chk("j1_wa_m27",    32'(r_wa[27]), 32'd963);
    chk("j1_done_idx",  32'(done_idx), 32'd28);
    chk("j1_done_cnt",  32'(done_cnt), 32'd1);
    chk("j1_busy_m28",  32'(r_busy[28]), 32'd0);
    chk("j1_read_m28",  32'(r_read[28]), 32'd0);
    chk("j1_wen_m28",   32'(r_wen[28]), 32'd0);
`ifdef TILE_SCHED_PERF_EN
    chk("j1_perf",      bus.perf_cycles, 32'd29);
`endif

    // Job 2: rows=45 cols=2 -> tiles of 20, 20, 5 rows
    run_job(10'd45, 10'd2, 120, 0, 0);
    chk("j2_wb_t0",     32'(r_wb[2]), 32'd64);
    chk("j2_wb_t1",     32'(r_wb[44]), 32'd104);
    chk("j2_wb_t2",     32'(r_wb[86]), 32'd144);
    chk("j2_arr_cnt",   32'(arr_cnt), 32'd3);
    chk("j2_wen_cnt",   32'(wen_cnt), 32'd45);
    chk("j2_read_cnt",  32'(read_cnt), 32'd108);
    chk("j2_wa_m23",    32'(r_wa[23]), 32'd960);
    chk("j2_wa_m42",    32'(r_wa[42]), 32'd979);
    chk("j2_wa_m65",    32'(r_wa[65]), 32'd980);
    chk("j2_wa_m107",   32'(r_wa[107]), 32'd1000);
    chk("j2_wa_m111",   32'(r_wa[111]), 32'd1004);
    chk("j2_wen_m106",  32'(r_wen[106]), 32'd0);
    chk("j2_wen_m111",  32'(r_wen[111]), 32'd1);
    chk("j2_done_idx",  32'(done_idx), 32'd112);

    // Job 3: empty jobs finish immediately with no array activity
    run_job(10'd0, 10'd5, 6, 0, 0);
    chk("j3_done_idx",  32'(done_idx), 32'd1);
    chk("j3_busy_m1",   32'(r_busy[1]), 32'd0);
    chk("j3_activity",  32'(read_cnt + arr_cnt + wen_cnt), 32'd0);
    run_job(10'd3, 10'd0, 6, 0, 0);
    chk("j3b_done_idx", 32'(done_idx), 32'd1);
    chk("j3b_activity", 32'(read_cnt + arr_cnt + wen_cnt), 32'd0);

    // Job 4: second start during FEED is ignored
    run_job(10'd4, 10'd3, 40, 3, 0);
    chk("j4_done_idx",  32'(done_idx), 32'd28);
    chk("j4_done_cnt",  32'(done_cnt), 32'd1);
    chk("j4_wen_cnt",   32'(wen_cnt), 32'd4);

    // Job 5: reset during DRAIN aborts without done; next job runs normally
    run_job(10'd4, 10'd3, 40, 0, 10);
    chk("j5_idle_m10",  32'(r_idle[10]), 32'd1);
    chk("j5_busy_m10",  32'(r_busy[10]), 32'd0);
    chk("j5_read_m10",  32'(r_read[10]), 32'd0);
    chk("j5_done_cnt",  32'(done_cnt), 32'd0);
    run_job(10'd4, 10'd3, 35, 0, 0);
    chk("j6_done_idx",  32'(done_idx), 32'd28);
    chk("j6_wen_cnt",   32'(wen_cnt), 32'd4);
    chk("j6_wa_m24",    32'(r_wa[24]), 32'd960);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tile_scheduler.md
TILE_SCHEDULER -- requirements
Module: tile_scheduler

Interface
REQ-001 SHALL have parameter PE_NUMBER, default 20, giving the number of PEs in the systolic array (the rows per tile).
REQ-002 SHALL have parameter ADDR_W, default 10, giving the memory address width.
REQ-003 SHALL have parameter VEC_BASE, default 0, giving the vector start address.
REQ-004 SHALL have parameter MAT_BASE, default 64, giving the matrix start address; the matrix is stored row-major.
REQ-005 SHALL have parameter RES_BASE, default 960, giving the result start address.
REQ-006 SHALL provide port: clk  in  1  system clock; single clock domain.
REQ-007 SHALL provide port: rst_n  in  1  reset; synchronous, active-low.
REQ-008 SHALL provide port: start  in  1  one-cycle pulse that starts a job.
REQ-009 SHALL provide port: mat_rows  in  ADDR_W  matrix row count; sampled at start.
REQ-010 SHALL provide port: mat_cols  in  ADDR_W  matrix column count, which is also the vector length; sampled at start.
REQ-011 SHALL provide port: busy  out  1  high from acceptance of start until done.
REQ-012 SHALL provide port: done  out  1  one-cycle pulse at job end.
REQ-013 SHALL provide port: arr_reset  out  1  clears the systolic-array accumulators.
REQ-014 SHALL provide port: read  out  1  advances the systolic array by one step.
REQ-015 SHALL provide port: l_d_o_addr  out  ADDR_W  vector element address.
REQ-016 SHALL provide port: w_base_addr  out  ADDR_W  weight address of PE0 in the current step; PE i reads w_base_addr + i*mat_cols.
REQ-017 SHALL provide port: res_wen  out  1  result write enable.
REQ-018 SHALL provide port: res_waddr  out  ADDR_W  result write address.

Function
REQ-019 SHALL implement the FSM states IDLE, CLEAR, FEED, DRAIN, STORE and FIN.
REQ-020 SHALL, in IDLE, go to CLEAR when start=1 with mat_rows!=0 and mat_cols!=0, and latch rows, cols, tile=0, k=0.
REQ-021 SHALL, in IDLE, go to FIN when start=1 with mat_rows=0 or mat_cols=0, with no array activity.
REQ-022 SHALL, in CLEAR, assert arr_reset=1 for exactly 1 cycle and then go to FEED.
REQ-023 SHALL, in FEED, assert read=1 for cols cycles; on step k: l_d_o_addr=VEC_BASE+k, w_base_addr=MAT_BASE+tile*PE_NUMBER*cols+k; go to DRAIN after k=cols-1.
REQ-024 SHALL, in DRAIN, assert read=1 for PE_NUMBER-1 cycles to flush the pipeline skew, then go to STORE.
REQ-025 SHALL, in STORE, assert res_wen=1 for n cycles, where n=min(PE_NUMBER, rows-tile*PE_NUMBER); res_waddr=RES_BASE+tile*PE_NUMBER+j for j=0..n-1; read=1 on the same cycles to shift out each result.
REQ-026 SHALL, after STORE, go to CLEAR with tile+1 if rows remain, otherwise to FIN.
REQ-027 SHALL, in FIN, pulse done=1 for 1 cycle, drop busy in the same cycle, and go to IDLE.
REQ-028 SHALL ignore start while busy=1.
REQ-029 SHALL compute all addresses modulo 2^ADDR_W and wrap silently.
REQ-030 SHALL write only the valid rows of a partial last tile; PEs beyond the last row are not written.
REQ-031 SHALL hold arr_reset, read and res_wen low in IDLE and FIN.
REQ-032 SHALL have job latency sum over tiles of (1+cols+PE_NUMBER-1+n), plus 1 cycle for FIN.

Reset
REQ-033 SHALL, on a clk edge with rst_n=0, force state to IDLE and all outputs to 0, and clear the counters.
REQ-034 SHALL, on rst_n=0 mid-job, abort the job with no done pulse; any partial results are left as written.

Configuration
REQ-035 SHALL, when TILE_SCHED_PERF_EN is defined, add output perf_cycles (32-bit) counting cycles with busy=1, cleared at job start and held after done.
REQ-036 SHALL, when TILE_SCHED_PERF_EN is undefined, omit the perf_cycles port and its logic entirely.

Structure
REQ-037 SHALL place the state enum tile_sched_state_t and the default base-address constants in package tile_sched_pkg.
REQ-038 SHALL place the min(PE_NUMBER, rows remaining) computation and the tile-base multiply in sub-module tile_addr_gen; the FSM stays in tile_scheduler.

Verification
REQ-039 SHALL verify rows=4, cols=3, PE_NUMBER=20 -> 1 tile; CLEAR 1, FEED 3 (l_d_o_addr 0,1,2), DRAIN 19, STORE 4 (res_waddr 960..963); done at cycle 29.
REQ-040 SHALL verify rows=45, cols=2 -> 3 tiles; STORE lengths 20, 20, 5; w_base_addr at FEED start = 64, 104, 144.
REQ-041 SHALL verify start with rows=0 -> done 2 cycles after start; read, arr_reset and res_wen stay 0.
REQ-042 SHALL verify a second start pulse during FEED -> ignored; the single done occurs at the original latency.
REQ-043 SHALL verify rst_n=0 during DRAIN -> next cycle state IDLE, busy=0, no done pulse; a new start then runs normally.
REQ-044 SHALL verify, with TILE_SCHED_PERF_EN defined, the REQ-039 job -> perf_cycles=29 after done.
